interp_line_streamer: RTL and testbench

INTERP_LINE_STREAMER -- requirements
Module: interp_line_streamer

---
 rtl/interp_pkg.sv | 22 ++
 rtl/interp_line_select.sv | 46 ++++
 rtl/interp_line_streamer.sv | 114 +++++++++++
 tb/tb_interp_line_streamer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interp_pkg.sv
// Shared encodings for the interpolation line streamer: job modes, streamer
// states and the window-edge derivation used to size every port.
package interp_pkg;

    typedef enum logic [1:0] {
        MODE_INT    = 2'd0,
        MODE_HALF_A = 2'd1,
        MODE_HALF_B = 2'd2,
        MODE_HALF_C = 2'd3
    } interp_mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } stream_state_e;

    // A block of NUM_PIXEL outputs needs TAPS-1 extra neighbours per edge.
    function automatic int win_edge(input int num_pixel, input int taps);
        return num_pixel + taps - 1;
    endfunction

endpackage

// File: rtl/interp_line_select.sv
// Combinational lane-vector selector: picks a row or column of the integer
// window, or a transposed column of the half-pel plane, for one line index.
module interp_line_select
    import interp_pkg::*;
#(
    parameter int  NUM_PIXEL = 8,
    parameter int  TAPS      = 8,
    parameter int  INT_W     = 8,
    parameter int  HALF_W    = 16,
    localparam int WIN       = win_edge(NUM_PIXEL, TAPS)
) (
    input  logic [WIN*WIN*INT_W-1:0]        int_buf,
    input  logic [WIN*NUM_PIXEL*HALF_W-1:0] half_buf,
    input  logic [7:0]                      index,
    input  logic [1:0]                      mode,
    output logic [WIN*HALF_W-1:0]           line
);

    localparam int PAD_W = HALF_W - INT_W;

    int idx;

    // Indices beyond the job's last line select nothing and yield zeros.
    always_comb begin
        line = '0;
        idx  = int'(index);
        if (mode == MODE_INT) begin
            if (idx < WIN) begin
                for (int k = 0; k < WIN; k++) begin
                    line[k*HALF_W +: HALF_W] = {{PAD_W{1'b0}}, int_buf[(idx*WIN + k)*INT_W +: INT_W]};
                end
            end else if (idx < 2*WIN) begin
                for (int k = 0; k < WIN; k++) begin
                    line[k*HALF_W +: HALF_W] = {{PAD_W{1'b0}}, int_buf[(k*WIN + idx - WIN)*INT_W +: INT_W]};
                end
            end
        end else begin
            if (idx < NUM_PIXEL) begin
                for (int k = 0; k < WIN; k++) begin
                    line[k*HALF_W +: HALF_W] = half_buf[(k*NUM_PIXEL + idx)*HALF_W +: HALF_W];
                end
            end
        end
    end

endmodule

// File: rtl/interp_line_streamer.sv
// Captures an interpolation window on start and streams it out line by line
// (rows then columns for integer jobs, transposed columns for half-pel jobs).
module interp_line_streamer
    import interp_pkg::*;
#(
    parameter int  NUM_PIXEL = 8,
    parameter int  TAPS      = 8,
    parameter int  INT_W     = 8,
    parameter int  HALF_W    = 16,
    localparam int WIN       = win_edge(NUM_PIXEL, TAPS)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic [1:0]                      mode,
    input  logic [WIN*WIN*INT_W-1:0]        int_win,
    input  logic [WIN*NUM_PIXEL*HALF_W-1:0] half_plane,
    output logic                            busy,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIN*HALF_W-1:0]           out_line,
    output logic [7:0]                      out_index,
    output logic                            out_last,
    output logic [1:0]                      out_mode
);

    localparam logic [7:0] LAST_INT  = 8'(2*WIN - 1);
    localparam logic [7:0] LAST_HALF = 8'(NUM_PIXEL - 1);

    stream_state_e                   state;
    logic [WIN*WIN*INT_W-1:0]        int_buf;
    logic [WIN*NUM_PIXEL*HALF_W-1:0] half_buf;
    logic [WIN*HALF_W-1:0]           sel_line;
    logic                            accept;
    logic                            handshake;
    logic [7:0]                      last_index;
    logic [7:0]                      first_last;
    logic [7:0]                      next_index;

    assign accept     = (state == ST_IDLE) && start;
    assign handshake  = out_valid && out_ready;
    assign last_index = (out_mode == MODE_INT) ? LAST_INT : LAST_HALF;
    assign first_last = (mode == MODE_INT) ? LAST_INT : LAST_HALF;
    assign next_index = out_index + 8'd1;

    // Only the buffer the job actually reads is loaded; the other keeps stale data.
    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            if (mode == MODE_INT) begin
                int_buf <= int_win;
            end else begin
                half_buf <= half_plane;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_index <= 8'd0;
            out_last  <= 1'b0;
            out_mode  <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_STREAM;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_index <= 8'd0;
                        out_last  <= (first_last == 8'd0);
                        out_mode  <= mode;
                    end
                end
                ST_STREAM: begin
                    if (handshake) begin
                        if (out_last) begin
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            out_index <= 8'd0;
                            out_last  <= 1'b0;
                        end else begin
                            out_index <= next_index;
                            out_last  <= (next_index == last_index);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    interp_line_select #(
        .NUM_PIXEL (NUM_PIXEL),
        .TAPS      (TAPS),
        .INT_W     (INT_W),
        .HALF_W    (HALF_W)
    ) u_select (
        .int_buf  (int_buf),
        .half_buf (half_buf),
        .index    (out_index),
        .mode     (out_mode),
        .line     (sel_line)
    );

    // Gating on out_valid also hides uninitialised buffers after reset.
    assign out_line = out_valid ? sel_line : '0;

endmodule

// File: tb/tb_interp_line_streamer.sv
// Randomised self-checking bench for interp_line_streamer against an array
// model of the window and half-pel plane.
module tb_interp_line_streamer;

    localparam int NP  = 8;
    localparam int TP  = 8;
    localparam int IW  = 8;
    localparam int HW  = 16;
    localparam int WIN = NP + TP - 1;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    start;
    logic [1:0]              mode;
    logic [WIN*WIN*IW-1:0]   int_win;
    logic [WIN*NP*HW-1:0]    half_plane;
    logic                    busy;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIN*HW-1:0]       out_line;
    logic [7:0]              out_index;
    logic                    out_last;
    logic [1:0]              out_mode;

    interp_line_streamer #(
        .NUM_PIXEL (NP),
        .TAPS      (TP),
        .INT_W     (IW),
        .HALF_W    (HW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .int_win    (int_win),
        .half_plane (half_plane),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_line   (out_line),
        .out_index  (out_index),
        .out_last   (out_last),
        .out_mode   (out_mode)
    );

    always #5 clock = ~clock;

    logic [IW-1:0]     pix [WIN][WIN];
    logic [HW-1:0]     hp  [WIN][NP];
    int                n_checks = 0;
    int                n_fail   = 0;
    logic [WIN*HW-1:0] got_line [64];
    int                got_idx  [64];
    logic              got_last [64];
    logic [1:0]        got_mode [64];
    int                got_n;
    int                got_cycles;
    bit                got_timeout;

    // Reference: integer jobs are rows then columns, half jobs are transposed columns.
    function automatic logic [WIN*HW-1:0] model_line(input int m, input int idx);
        logic [WIN*HW-1:0] l;
        l = '0;
        for (int k = 0; k < WIN; k++) begin
            if (m == 0) l[k*HW +: HW] = (idx < WIN) ? {8'h00, pix[idx][k]} : {8'h00, pix[k][idx-WIN]};
            else        l[k*HW +: HW] = hp[k][idx];
        end
        return l;
    endfunction

    function automatic int model_count(input int m);
        return (m == 0) ? 2*WIN : NP;
    endfunction

    task automatic fill_pattern();
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) pix[r][c] = 8'(r*16 + c);
            for (int c = 0; c < NP; c++)  hp[r][c]  = 16'(256*r + c);
        end
    endtask

    task automatic fill_random();
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) pix[r][c] = 8'($urandom);
            for (int c = 0; c < NP; c++)  hp[r][c]  = 16'($urandom);
        end
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < WIN*WIN; i++) int_win[i*IW +: IW] = 8'($urandom);
        for (int i = 0; i < WIN*NP; i++)  half_plane[i*HW +: HW] = 16'($urandom);
    endtask

    // Drives one accepted start, then scrambles the data ports so late reads would show.
    task automatic start_job(input int m);
        @(negedge clock);
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) int_win[(r*WIN + c)*IW +: IW] = pix[r][c];
            for (int c = 0; c < NP; c++)  half_plane[(r*NP + c)*HW +: HW] = hp[r][c];
        end
        mode  = m[1:0];
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        scramble_inputs();
    endtask

    task automatic stream_job(input int ready_pct);
        got_n = 0;
        got_cycles = 0;
        got_timeout = 1'b1;
        for (int cyc = 0; cyc < 500; cyc++) begin
            out_ready = ($urandom_range(99) < ready_pct);
            got_cycles++;
            if (out_valid && out_ready && got_n < 64) begin
                got_line[got_n] = out_line;
                got_idx[got_n]  = int'(out_index);
                got_last[got_n] = out_last;
                got_mode[got_n] = out_mode;
                got_n++;
                if (out_last) begin
                    @(negedge clock);
                    out_ready = 1'b0;
                    got_timeout = 1'b0;
                    return;
                end
            end
            @(negedge clock);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b0; mode = 2'd0;
        scramble_inputs();
        repeat (3) @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got %b want 0", out_valid); end
        n_checks++; if (out_line !== '0) begin n_fail++; $display("[TB] FAIL reset_line got %h want 0", out_line); end
        n_checks++; if (out_index !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_index got %0d want 0", out_index); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_last got %b want 0", out_last); end
        n_checks++; if (out_mode !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_mode got %0d want 0", out_mode); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_int_pattern();
        logic [WIN*HW-1:0] exp3, exp18;
        for (int k = 0; k < WIN; k++) begin
            exp3[k*HW +: HW]  = 16'(48 + k);
            exp18[k*HW +: HW] = 16'(3 + 16*k);
        end
        fill_pattern();
        start_job(0);
        stream_job(100);
        n_checks++; if (got_timeout || got_n != 30) begin n_fail++; $display("[TB] FAIL int_count got %0d want 30 (timeout %0b)", got_n, got_timeout); end
        n_checks++; if (got_cycles != 30) begin n_fail++; $display("[TB] FAIL int_cycles got %0d want 30", got_cycles); end
        for (int i = 0; i < got_n; i++) begin
            n_checks++; if (got_line[i] !== model_line(0, i)) begin n_fail++; $display("[TB] FAIL int_line[%0d] got %h want %h", i, got_line[i], model_line(0, i)); end
            n_checks++; if (got_idx[i] != i || got_last[i] !== (i == 29) || got_mode[i] !== 2'd0) begin n_fail++; $display("[TB] FAIL int_meta[%0d] got idx %0d last %b mode %0d", i, got_idx[i], got_last[i], got_mode[i]); end
        end
        n_checks++; if (got_line[3] !== exp3) begin n_fail++; $display("[TB] FAIL int_row3 got %h want %h", got_line[3], exp3); end
        n_checks++; if (got_line[18] !== exp18) begin n_fail++; $display("[TB] FAIL int_col3 got %h want %h", got_line[18], exp18); end
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL int_idle got busy %b valid %b want 0 0", busy, out_valid); end
    endtask

    task automatic test_half_b();
        logic [WIN*HW-1:0] exp5;
        for (int k = 0; k < WIN; k++) exp5[k*HW +: HW] = 16'(256*k + 5);
        fill_pattern();
        start_job(2);
        stream_job(100);
        n_checks++; if (got_timeout || got_n != 8) begin n_fail++; $display("[TB] FAIL halfb_count got %0d want 8", got_n); end
        for (int i = 0; i < got_n; i++) begin
            n_checks++; if (got_line[i] !== model_line(2, i)) begin n_fail++; $display("[TB] FAIL halfb_line[%0d] got %h want %h", i, got_line[i], model_line(2, i)); end
            n_checks++; if (got_idx[i] != i || got_last[i] !== (i == 7) || got_mode[i] !== 2'd2) begin n_fail++; $display("[TB] FAIL halfb_meta[%0d] got idx %0d last %b mode %0d", i, got_idx[i], got_last[i], got_mode[i]); end
        end
        n_checks++; if (got_line[5] !== exp5) begin n_fail++; $display("[TB] FAIL halfb_line5 got %h want %h", got_line[5], exp5); end
    endtask

    task automatic test_random_jobs();
        int m;
        repeat (6) begin
            fill_random();
            m = int'($urandom_range(3));
            start_job(m);
            stream_job(60);
            n_checks++; if (got_timeout || got_n != model_count(m)) begin n_fail++; $display("[TB] FAIL rand_count mode %0d got %0d want %0d", m, got_n, model_count(m)); end
            for (int i = 0; i < got_n; i++) begin
                n_checks++; if (got_line[i] !== model_line(m, i)) begin n_fail++; $display("[TB] FAIL rand_line[%0d] mode %0d got %h want %h", i, m, got_line[i], model_line(m, i)); end
                n_checks++; if (got_idx[i] != i || got_last[i] !== (i == model_count(m) - 1) || got_mode[i] !== m[1:0]) begin n_fail++; $display("[TB] FAIL rand_meta[%0d] got idx %0d last %b mode %0d", i, got_idx[i], got_last[i], got_mode[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        bit done = 1'b0;
        fill_random();
        start_job(0);
        for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
            out_ready = !(cyc >= 4 && cyc <= 9);
            if (cyc >= 4 && cyc <= 9) begin
                n_checks++; if (out_index !== 8'd3 || out_line !== model_line(0, 3)) begin n_fail++; $display("[TB] FAIL bp_hold cyc %0d got idx %0d line %h want idx 3", cyc, out_index, out_line); end
            end
            if (out_valid && out_ready) begin
                n_checks++; if (int'(out_index) != n || out_line !== model_line(0, n)) begin n_fail++; $display("[TB] FAIL bp_line got idx %0d line %h want idx %0d line %h", out_index, out_line, n, model_line(0, n)); end
                n++;
                done = out_last;
            end
            @(negedge clock);
        end
        out_ready = 1'b0;
        n_checks++; if (n != 30) begin n_fail++; $display("[TB] FAIL bp_count got %0d want 30", n); end
    endtask

    task automatic test_start_ignored();
        int n = 0;
        bit done = 1'b0;
        fill_random();
        start_job(0);
        for (int cyc = 1; cyc <= 100 && !done; cyc++) begin
            out_ready = 1'b1;
            start = (cyc == 5);
            if (cyc == 5) begin mode = 2'd1; scramble_inputs(); end
            if (out_valid) begin
                n_checks++; if (int'(out_index) != n || out_line !== model_line(0, n) || out_mode !== 2'd0) begin n_fail++; $display("[TB] FAIL ign_line got idx %0d mode %0d line %h want idx %0d line %h", out_index, out_mode, out_line, n, model_line(0, n)); end
                n++;
                done = out_last;
            end
            @(negedge clock);
        end
        start = 1'b0; out_ready = 1'b0;
        n_checks++; if (n != 30) begin n_fail++; $display("[TB] FAIL ign_count got %0d want 30", n); end
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        fill_random();
        start_job(0);
        for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
            out_ready = 1'b1;
            if (out_valid && out_index == 8'd10) hit = 1'b1;
            else @(negedge clock);
        end
        n_checks++; if (!hit) begin n_fail++; $display("[TB] FAIL rstmid_reach got idx %0d want 10", out_index); end
        reset = 1'b1; out_ready = 1'b0;
        @(negedge clock);
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_ctrl got valid %b busy %b want 0 0", out_valid, busy); end
        n_checks++; if (out_line !== '0 || out_index !== 8'd0) begin n_fail++; $display("[TB] FAIL rstmid_data got idx %0d line %h want 0", out_index, out_line); end
        reset = 1'b0;
        fill_random();
        start_job(3);
        stream_job(100);
        n_checks++; if (got_timeout || got_n != 8) begin n_fail++; $display("[TB] FAIL rstmid_count got %0d want 8", got_n); end
        for (int i = 0; i < got_n; i++) begin
            n_checks++; if (got_idx[i] != i || got_line[i] !== model_line(3, i)) begin n_fail++; $display("[TB] FAIL rstmid_line[%0d] got idx %0d line %h want %h", i, got_idx[i], got_line[i], model_line(3, i)); end
        end
    endtask

    task automatic test_start_at_last();
        bit hit = 1'b0;
        fill_random();
        start_job(1);
        for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
            out_ready = 1'b1;
            if (out_valid && out_last) begin
                start = 1'b1; mode = 2'd0; hit = 1'b1;
            end
            @(negedge clock);
        end
        start = 1'b0; out_ready = 1'b0;
        n_checks++; if (!hit) begin n_fail++; $display("[TB] FAIL last_reach got no out_last"); end
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL last_ignore got busy %b valid %b want 0 0", busy, out_valid); end
        fill_random();
        start_job(0);
        n_checks++; if (out_valid !== 1'b1 || out_index !== 8'd0 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL last_restart got valid %b idx %0d busy %b want 1 0 1", out_valid, out_index, busy); end
        stream_job(100);
        n_checks++; if (got_timeout || got_n != 30) begin n_fail++; $display("[TB] FAIL last_count got %0d want 30", got_n); end
        for (int i = 0; i < got_n; i++) begin
            n_checks++; if (got_idx[i] != i || got_line[i] !== model_line(0, i)) begin n_fail++; $display("[TB] FAIL last_line[%0d] got idx %0d line %h want %h", i, got_idx[i], got_line[i], model_line(0, i)); end
        end
    endtask

    initial begin
        test_reset();
        test_int_pattern();
        test_half_b();
        test_random_jobs();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_start_at_last();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired after %0d checks", n_checks);
        $fatal(1, "[TB] watchdog");
    end

endmodule
